// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and the downstream 8-to-3 encoder.
package arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } arb_state_e;

    function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDX_W-1:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_chk.sv
// Property checker for the arbiter outputs; bind or instantiate alongside rr_arbiter8.
module rr_arbiter8_chk
    import arb_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    input logic [ARB_N-1:0] gnt,
    input logic             gnt_valid,
    input logic             timeout
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_valid_match: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
    a_to_released: assert property (@(posedge clk) disable iff (!rst_n) timeout |-> !gnt_valid);

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: rotate so the search start sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] last,
    output logic [ARB_N-1:0]     win_onehot,
    output logic [ARB_IDX_W-1:0] win_idx,
    output logic                 any
);

    logic [ARB_IDX_W-1:0] start_s;
    logic [2*ARB_N-1:0]   dbl_s;
    logic [ARB_N-1:0]     rot_s;
    logic [ARB_IDX_W-1:0] pos_s;

    assign start_s = last + 3'd1;
    assign dbl_s   = {req, req};
    assign rot_s   = dbl_s[start_s +: ARB_N];

    // Fixed-priority pick on the rotated vector; scanning downward leaves the lowest set bit.
    always_comb begin
        pos_s = 3'd0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            pos_s = rot_s[i] ? 3'(i) : pos_s;
        end
    end

    assign any        = |req;
    assign win_idx    = pos_s + start_s;
    assign win_onehot = any ? idx_to_onehot(win_idx) : 8'h00;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-input round-robin arbiter with registered one-hot grant, done release and hold timeout.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ARB_N-1:0] req,
    input  logic             done,
    output logic [ARB_N-1:0] gnt,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e           state_r;
    logic [ARB_IDX_W-1:0] last_r;
    logic [ARB_IDX_W-1:0] owner_r;
    logic [CNT_W-1:0]     hold_cnt_r;
    logic [ARB_N-1:0]     gnt_r;
    logic                 gnt_valid_r;
    logic                 timeout_r;

    logic [ARB_N-1:0]     win_onehot_s;
    logic [ARB_IDX_W-1:0] win_idx_s;
    logic                 any_s;

    rr_pick8 u_pick (
        .req        (req),
        .last       (last_r),
        .win_onehot (win_onehot_s),
        .win_idx    (win_idx_s),
        .any        (any_s)
    );

    // Grant FSM; req is ignored while a grant is held, and last advances on either release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            last_r      <= 3'd7;
            owner_r     <= 3'd0;
            hold_cnt_r  <= '0;
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    timeout_r  <= 1'b0;
                    hold_cnt_r <= '0;
                    if (any_s) begin
                        gnt_r       <= win_onehot_s;
                        gnt_valid_r <= 1'b1;
                        owner_r     <= win_idx_s;
                        state_r     <= S_GRANT;
                    end else begin
                        gnt_r       <= 8'h00;
                        gnt_valid_r <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (done || (hold_cnt_r == HOLD_LAST)) begin
                        gnt_r       <= 8'h00;
                        gnt_valid_r <= 1'b0;
                        last_r      <= owner_r;
                        timeout_r   <= !done;
                        hold_cnt_r  <= '0;
                        state_r     <= S_IDLE;
                    end else begin
                        hold_cnt_r  <= hold_cnt_r + 1'b1;
                        timeout_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    gnt_r       <= 8'h00;
                    gnt_valid_r <= 1'b0;
                    timeout_r   <= 1'b0;
                    hold_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random bench for rr_arbiter8 with a per-cycle scoreboard and an encoder model.
module tb_rr_arbiter8;
    import arb_pkg::*;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic       to;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];

    bit         m_busy;
    logic [2:0] m_last;
    logic [2:0] m_owner;
    int         m_cnt;
    logic [7:0] m_gnt;
    logic       m_to;
    int         wait_cnt[8];

    localparam logic [7:0] RP_SEQ [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h01};

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_arbiter8_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Behavioural 8-to-3 one-hot encoder sitting downstream of gnt.
    function automatic logic [2:0] enc8(input logic [7:0] i);
        logic [2:0] y;
        y = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (i[k]) y = y | 3'(k);
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_last  = 3'd7;
        m_owner = 3'd0;
        m_cnt   = 0;
        m_gnt   = 8'h00;
        m_to    = 1'b0;
        for (int k = 0; k < 8; k++) wait_cnt[k] = 0;
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        exp_t e;
        bit   found;
        int   k;
        req  = r;
        done = d;
        if (!m_busy) begin
            m_to = 1'b0;
            if (r != 8'h00) begin
                found = 1'b0;
                for (int i = 1; i <= 8; i++) begin
                    k = (int'(m_last) + i) % 8;
                    if (!found && r[k]) begin
                        m_owner = 3'(k);
                        found   = 1'b1;
                    end
                end
                m_gnt  = 8'h01 << m_owner;
                m_busy = 1'b1;
                m_cnt  = 0;
                for (int j = 0; j < 8; j++) begin
                    if (j == int'(m_owner)) wait_cnt[j] = 0;
                    else if (r[j]) begin
                        wait_cnt[j]++;
                        chk("fairness", 8'(wait_cnt[j] <= 7), 8'd1);
                    end
                end
            end else begin
                m_gnt = 8'h00;
            end
        end else if (d) begin
            m_gnt  = 8'h00;
            m_busy = 1'b0;
            m_last = m_owner;
            m_to   = 1'b0;
        end else if (m_cnt == MAX_HOLD - 1) begin
            m_gnt  = 8'h00;
            m_busy = 1'b0;
            m_last = m_owner;
            m_to   = 1'b1;
        end else begin
            m_cnt++;
            m_to = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
            if (!r[j]) wait_cnt[j] = 0;
        end
        sb.push_back('{gnt: m_gnt, to: m_to, idx: m_owner});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("gnt_valid", 8'(gnt_valid), 8'(|e.gnt));
        chk("timeout", 8'(timeout), 8'(e.to));
        if (gnt_valid) chk("enc_y", 8'(enc8(gnt)), 8'(e.idx));
    endtask

    initial begin
        logic [7:0] cur_req;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();
        #12;
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_valid", 8'(gnt_valid), 8'h00);
        chk("rst_timeout", 8'(timeout), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset priority: requester 0 first, then rotate with a bubble between grants.
        for (int n = 0; n < 9; n++) begin
            step(8'hFF, 1'b0);
            chk("rp_grant", gnt, RP_SEQ[n]);
            step(8'hFF, 1'b0);
            step(8'hFF, 1'b1);
            chk("rp_bubble", gnt, 8'h00);
        end

        // Wrap-around from last = 6.
        step(8'h40, 1'b0);
        chk("wrap_setup", gnt, 8'h40);
        step(8'h40, 1'b1);
        step(8'h41, 1'b0);
        chk("wrap_first", gnt, 8'h01);
        step(8'h41, 1'b1);
        step(8'h41, 1'b0);
        chk("wrap_second", gnt, 8'h40);
        step(8'h41, 1'b1);

        // Timeout: exactly MAX_HOLD cycles of grant, then a one-cycle timeout pulse.
        step(8'h08, 1'b0);
        chk("to_gnt1", gnt, 8'h08);
        step(8'h08, 1'b0);
        step(8'h08, 1'b0);
        step(8'h08, 1'b0);
        chk("to_gnt4", gnt, 8'h08);
        step(8'h0C, 1'b0);
        chk("to_drop", gnt, 8'h00);
        chk("to_pulse", 8'(timeout), 8'h01);
        step(8'h0C, 1'b0);
        chk("to_next", gnt, 8'h04);
        chk("to_clear", 8'(timeout), 8'h00);
        step(8'h0C, 1'b1);

        // done on the final count releases without a timeout pulse.
        step(8'h02, 1'b0);
        step(8'h02, 1'b0);
        step(8'h02, 1'b0);
        step(8'h02, 1'b0);
        chk("sim_held", gnt, 8'h02);
        step(8'h02, 1'b1);
        chk("sim_drop", gnt, 8'h00);
        chk("sim_no_to", 8'(timeout), 8'h00);

        // done in IDLE is ignored; an owner dropping req keeps its grant.
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("idle_done", gnt, 8'h00);
        step(8'h10, 1'b0);
        chk("own_gnt", gnt, 8'h10);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("own_hold", gnt, 8'h10);
        step(8'h00, 1'b1);
        chk("own_rel", gnt, 8'h00);

        // Asynchronous reset between edges while gnt = 20.
        step(8'h20, 1'b0);
        step(8'h20, 1'b0);
        chk("mr_pre", gnt, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_gnt", gnt, 8'h00);
        chk("mr_valid", 8'(gnt_valid), 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h21, 1'b0);
        chk("mr_after", gnt, 8'h01);
        step(8'h21, 1'b1);

        // Random traffic with encoder and fairness checking.
        cur_req = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) cur_req = 8'($urandom);
            step(cur_req, ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
